// File: rtl/bmux_frag_pkg.sv
// rtl/bmux_frag_pkg.sv - shared types and sizing helpers for the B-side mux fragment
package bmux_frag_pkg;

  typedef enum logic [1:0] {
    CFG_RUN    = 2'd0,
    CFG_LOAD   = 2'd1,
    CFG_COMMIT = 2'd2
  } cfg_state_e;

  // Number of mux inputs for a given branch/select split.
  function automatic int calc_n(input int br_w, input int sel_w);
    return 1 << (br_w + sel_w);
  endfunction

  // Bit count needed to hold 0..N inclusive so the load counter never wraps.
  function automatic int calc_cnt_w(input int br_w, input int sel_w);
    return $clog2(calc_n(br_w, sel_w) + 1);
  endfunction

endpackage

// File: rtl/bmux_frag_cfg.sv
// rtl/bmux_frag_cfg.sv - serial inversion-mask loader with shadow register and commit/abort pulses
module bmux_frag_cfg
  import bmux_frag_pkg::*;
#(
  parameter int           N        = 4,
  parameter int           CNT_W    = 3,
  parameter logic [N-1:0] INV_INIT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_en,
  input  logic         cfg_di,
  output logic [N-1:0] mask,
  output logic         cfg_done,
  output logic         cfg_err
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_N   = CNT_W'(N);

  cfg_state_e       state, state_nxt;
  logic [N-1:0]     shadow, shadow_nxt, mask_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             done_nxt, err_nxt;
  logic [N:0]       shift_w;

  // Bits arrive LSB first, so new bits enter at the top and walk down to bit 0.
  assign shift_w = {cfg_di, shadow};

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CFG_RUN;
    else        state <= state_nxt;
  end

  // Next-state and datapath decisions; the live mask only changes in COMMIT.
  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    count_nxt  = count;
    mask_nxt   = mask;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    unique case (state)
      CFG_RUN: begin
        if (cfg_en) begin
          shadow_nxt = shift_w[N:1];
          count_nxt  = CNT_ONE;
          state_nxt  = (N == 1) ? CFG_COMMIT : CFG_LOAD;
        end
      end
      CFG_LOAD: begin
        if (cfg_en) begin
          shadow_nxt = shift_w[N:1];
          count_nxt  = count + CNT_ONE;
          if (count_nxt == CNT_N) state_nxt = CFG_COMMIT;
        end else begin
          shadow_nxt = '0;
          count_nxt  = '0;
          err_nxt    = 1'b1;
          state_nxt  = CFG_RUN;
        end
      end
      CFG_COMMIT: begin
        mask_nxt   = shadow;
        shadow_nxt = '0;
        count_nxt  = '0;
        done_nxt   = 1'b1;
        state_nxt  = CFG_RUN;
      end
      default: state_nxt = CFG_RUN;
    endcase
  end

  // Shadow, counter, live mask and the registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= '0;
      count    <= '0;
      mask     <= INV_INIT;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      shadow   <= shadow_nxt;
      count    <= count_nxt;
      mask     <= mask_nxt;
      cfg_done <= done_nxt;
      cfg_err  <= err_nxt;
    end
  end

endmodule

// File: rtl/bmux_frag_q.sv
// rtl/bmux_frag_q.sv - registered B-side mux fragment with runtime-loadable input inversion
module bmux_frag_q
  import bmux_frag_pkg::*;
#(
  parameter int SEL_W = 1,
  parameter int BR_W  = 1,
  parameter int PIPE  = 0,
  parameter logic [calc_n(BR_W, SEL_W)-1:0] INV_INIT = '0
) (
  input  logic                           QCK,
  input  logic                           QRTN,
  input  logic                           TBS,
  input  logic [BR_W-1:0]                XAB,
  input  logic [SEL_W-1:0]               XSL,
  input  logic [calc_n(BR_W, SEL_W)-1:0] XD,
  output logic                           XZ,
  input  logic                           QEN,
  input  logic                           QCLR,
  output logic                           QZ,
  input  logic                           CFG_EN,
  input  logic                           CFG_DI,
  output logic                           CFG_DONE,
  output logic                           CFG_ERR
);

  localparam int N     = calc_n(BR_W, SEL_W);
  localparam int CNT_W = calc_cnt_w(BR_W, SEL_W);

  logic [N-1:0]           mask;
  logic [N-1:0]           p;
  logic [BR_W+SEL_W-1:0]  idx;
  logic                   xzi;
  logic                   qz_d;

  bmux_frag_cfg #(
    .N        (N),
    .CNT_W    (CNT_W),
    .INV_INIT (INV_INIT)
  ) u_cfg (
    .clk      (QCK),
    .rst_n    (QRTN),
    .cfg_en   (CFG_EN),
    .cfg_di   (CFG_DI),
    .mask     (mask),
    .cfg_done (CFG_DONE),
    .cfg_err  (CFG_ERR)
  );

  // Branch bits are the high half of the index, so {XAB, XSL} addresses all N inputs exactly.
  assign p   = XD ^ mask;
  assign idx = {XAB, XSL};
  assign xzi = p[idx];
  assign XZ  = TBS & xzi;

  generate
    if (PIPE != 0) begin : g_pipe
      logic stage;
      // Input-capture stage; advances in lockstep with QZ under the same enable and clear.
      always_ff @(posedge QCK or negedge QRTN) begin
        if (!QRTN)     stage <= 1'b0;
        else if (QCLR) stage <= 1'b0;
        else if (QEN)  stage <= XZ;
      end
      assign qz_d = stage;
    end else begin : g_nopipe
      assign qz_d = XZ;
    end
  endgenerate

  // Output register; clear takes priority over enable.
  always_ff @(posedge QCK or negedge QRTN) begin
    if (!QRTN)     QZ <= 1'b0;
    else if (QCLR) QZ <= 1'b0;
    else if (QEN)  QZ <= qz_d;
  end

endmodule

// File: tb/tb_bmux_frag_q.sv
// tb/tb_bmux_frag_q.sv - scoreboard bench for bmux_frag_q (N=4 no pipe, N=16 piped)
module tb_bmux_frag_q;

  logic        clk;
  logic        rst_n;
  logic        tbs[2], qen[2], qclr[2], cfg_en[2], cfg_di[2];
  logic [15:0] xd[2];
  logic [3:0]  idx[2];

  logic xz0, qz0, done0, err0;
  logic xz1, qz1, done1, err1;

  bmux_frag_q dut0 (
    .QCK(clk), .QRTN(rst_n), .TBS(tbs[0]), .XAB(idx[0][1]), .XSL(idx[0][0]),
    .XD(xd[0][3:0]), .XZ(xz0), .QEN(qen[0]), .QCLR(qclr[0]), .QZ(qz0),
    .CFG_EN(cfg_en[0]), .CFG_DI(cfg_di[0]), .CFG_DONE(done0), .CFG_ERR(err0)
  );

  bmux_frag_q #(.SEL_W(2), .BR_W(2), .PIPE(1), .INV_INIT(16'hA5C3)) dut1 (
    .QCK(clk), .QRTN(rst_n), .TBS(tbs[1]), .XAB(idx[1][3:2]), .XSL(idx[1][1:0]),
    .XD(xd[1]), .XZ(xz1), .QEN(qen[1]), .QCLR(qclr[1]), .QZ(qz1),
    .CFG_EN(cfg_en[1]), .CFG_DI(cfg_di[1]), .CFG_DONE(done1), .CFG_ERR(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  bit mon_on = 0;
  bit rand1 = 0;
  logic [7:0] exp_q[$];

  // reference model state
  logic [15:0] mask_m[2], pend_bits[2];
  int          pend_cnt[2];
  bit          commit_m[2];
  logic        qz_m[2], stg_m[2], done_m[2], err_m[2];

  function automatic int nn(int d);
    return (d == 0) ? 4 : 16;
  endfunction

  function automatic bit piped(int d);
    return d == 1;
  endfunction

  function automatic logic [15:0] inv0(int d);
    return (d == 0) ? 16'h0000 : 16'hA5C3;
  endfunction

  function automatic logic model_xz(int d);
    int i;
    i = int'(idx[d]) % nn(d);
    return tbs[d] & (xd[d][i] ^ mask_m[d][i]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mask_m[d] = inv0(d); pend_bits[d] = '0; pend_cnt[d] = 0; commit_m[d] = 0;
      qz_m[d] = 0; stg_m[d] = 0; done_m[d] = 0; err_m[d] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs held during the ending cycle.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      logic x;
      x = model_xz(d);
      done_m[d] = 0; err_m[d] = 0;
      if (!rst_n) continue;
      if (qclr[d]) begin
        qz_m[d] = 0; stg_m[d] = 0;
      end else if (qen[d]) begin
        qz_m[d] = piped(d) ? stg_m[d] : x;
        stg_m[d] = x;
      end
      if (commit_m[d]) begin
        mask_m[d] = pend_bits[d]; commit_m[d] = 0; done_m[d] = 1;
        pend_cnt[d] = 0; pend_bits[d] = '0;
      end else if (cfg_en[d]) begin
        pend_bits[d][pend_cnt[d]] = cfg_di[d];
        pend_cnt[d]++;
        if (pend_cnt[d] == nn(d)) commit_m[d] = 1;
      end else if (pend_cnt[d] > 0) begin
        pend_cnt[d] = 0; pend_bits[d] = '0; err_m[d] = 1;
      end
    end
  endtask

  task automatic push_exp();
    logic [7:0] e;
    for (int d = 0; d < 2; d++) begin
      e[d*4+3] = model_xz(d);
      e[d*4+2] = qz_m[d];
      e[d*4+1] = done_m[d];
      e[d*4+0] = err_m[d];
    end
    exp_q.push_back(e);
  endtask

  task automatic rand_dp(int d);
    xd[d]   = 16'($urandom);
    idx[d]  = 4'($urandom) & ((d == 0) ? 4'h3 : 4'hF);
    tbs[d]  = ($urandom_range(0, 99) < 85);
    qen[d]  = ($urandom_range(0, 99) < 60);
    qclr[d] = ($urandom_range(0, 99) < 10);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    if (rand1) rand_dp(1);
    push_exp();
    tick();
  endtask

  task automatic load_bits(int d, int n, logic [15:0] v);
    for (int i = 0; i < n; i++) begin
      cfg_en[d] = 1'b1; cfg_di[d] = v[i];
      cyc();
    end
    cfg_en[d] = 1'b0; cfg_di[d] = 1'b0;
  endtask

  task automatic sweep(int d);
    for (int i = 0; i < nn(d); i++) begin
      idx[d] = 4'(i);
      cyc();
    end
  endtask

  // Monitor: pops one expected record per cycle and compares every output field.
  always @(negedge clk) begin : monitor
    logic [7:0] e, g;
    string fname[4];
    fname = '{"err", "done", "qz", "xz"};
    if (mon_on) begin
      cyc_n++;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_underflow cyc=%0d got=empty required=entry", cyc_n);
      end else begin
        e = exp_q.pop_front();
        g = {xz1, qz1, done1, err1, xz0, qz0, done0, err0};
        for (int d = 0; d < 2; d++) begin
          for (int f = 0; f < 4; f++) begin
            checks++;
            if (g[d*4+f] !== e[d*4+f]) begin
              failures++;
              $display("FAIL %s dut%0d cyc=%0d got=%b required=%b",
                       fname[f], d, cyc_n, g[d*4+f], e[d*4+f]);
            end
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      tbs[d] = 0; qen[d] = 0; qclr[d] = 0; cfg_en[d] = 0; cfg_di[d] = 0;
      xd[d] = '0; idx[d] = '0;
    end
    model_reset();
    @(posedge clk);
    #1;
    mon_on = 1;
    rand1 = 1;

    // reset state and default-mask datapath
    xd[0] = 16'h0004; idx[0] = 4'd2; tbs[0] = 1; qen[0] = 0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    qen[0] = 1; cyc();
    qen[0] = 0; cyc();
    tbs[0] = 0; cyc();
    tbs[0] = 1;

    // full load of 4'b0101, then sweep with XD=0
    xd[0] = 16'h0000;
    load_bits(0, 4, 16'h0005);
    cyc(); cyc();
    sweep(0);

    // aborted load, then clean reload
    load_bits(0, 2, 16'h0003);
    cyc(); cyc();
    sweep(0);
    load_bits(0, 4, 16'h000A);
    cyc(); cyc();
    sweep(0);

    // clear beats enable, then hold with QEN low
    xd[0] = 16'h000F; idx[0] = 4'd0;
    qen[0] = 1; qclr[0] = 1; cyc();
    qclr[0] = 0; cyc();
    qen[0] = 0;
    for (int i = 0; i < 4; i++) begin
      xd[0] = 16'($urandom); cyc();
    end

    // back-to-back loads
    load_bits(0, 4, 16'h0006);
    load_bits(0, 4, 16'h0009);
    cyc(); cyc();
    sweep(0);

    // reset pulse mid-load
    cfg_en[0] = 1; cfg_di[0] = 1; cyc(); cyc();
    rst_n = 1'b0; model_reset(); cfg_en[0] = 0;
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    sweep(0);

    // wide, piped instance: full load, pipe latency and index sweep
    rand1 = 0;
    tbs[1] = 1; qclr[1] = 0; qen[1] = 1; xd[1] = 16'h0000; idx[1] = 4'd5;
    load_bits(1, 16, 16'h3C96);
    cyc(); cyc();
    xd[1] = 16'h0000; cyc();
    xd[1] = 16'hFFFF; cyc(); cyc(); cyc();
    for (int i = 0; i < 16; i++) begin
      xd[1] = 16'($urandom); idx[1] = 4'(i); cyc();
    end

    // randomized traffic on both instances
    for (int n = 0; n < 2000; n++) begin
      for (int d = 0; d < 2; d++) begin
        rand_dp(d);
        cfg_en[d] = ($urandom_range(0, 99) < ((d == 0) ? 75 : 92));
        cfg_di[d] = 1'($urandom);
      end
      push_exp();
      tick();
    end

    mon_on = 0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
